aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: drives an external SubBytes stage and applies ShiftRows/MixColumns/AddRoundKey.
// Optional build macro AES_SUB_TIMEOUT_EN adds a SUB_WAIT timeout, the ERR state and the err port.
module aes_round_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] pt,
    input  logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         sub_en,
    output logic [127:0] sub_data,
    input  logic         sub_valid,
    input  logic [127:0] sub_result,
    output logic         busy,
    output logic         done,
    output logic [127:0] ct
`ifdef AES_SUB_TIMEOUT_EN
    ,
    output logic         err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ARK0,
        SUB_REQ,
        SUB_WAIT,
        ROUND,
        DONE
`ifdef AES_SUB_TIMEOUT_EN
        ,
        ERR
`endif
    } fsm_t;

    fsm_t         r_fsm;
    logic [127:0] r_ptLatch;
    logic [127:0] r_aesState;
    logic [127:0] r_ct;
    logic [3:0]   r_roundIdx;
    logic         r_subEn;
    logic         r_busy;
    logic         r_done;
    logic [127:0] w_shifted;
    logic [127:0] w_mixed;
    logic [127:0] w_roundOut;

`ifdef AES_SUB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_waitCnt;
    logic             r_err;
    assign err = r_err;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixColumn(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte 4*c+r is row r of column c; row r rotates left by r columns.
    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mixColumn(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    always_comb begin
        w_shifted  = shiftRows(r_aesState);
        w_mixed    = mixColumns(w_shifted);
        w_roundOut = ((r_roundIdx == 4'd10) ? w_shifted : w_mixed) ^ round_key;
    end

    assign round_idx = r_roundIdx;
    assign sub_en    = r_subEn;
    assign sub_data  = r_aesState;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ct        = r_ct;

    // sub_en and done are one-cycle pulses, set on the transition into SUB_REQ/DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm      <= IDLE;
            r_ptLatch  <= '0;
            r_aesState <= '0;
            r_ct       <= '0;
            r_roundIdx <= '0;
            r_subEn    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef AES_SUB_TIMEOUT_EN
            r_waitCnt  <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_subEn <= 1'b0;
            r_done  <= 1'b0;
            if (abort && (r_fsm != IDLE)) begin
                r_fsm      <= IDLE;
                r_busy     <= 1'b0;
                r_roundIdx <= '0;
`ifdef AES_SUB_TIMEOUT_EN
                r_err      <= 1'b0;
`endif
            end else begin
                case (r_fsm)
                    IDLE: begin
                        if (start && !abort) begin
                            r_ptLatch  <= pt;
                            r_roundIdx <= '0;
                            r_busy     <= 1'b1;
                            r_fsm      <= ARK0;
                        end
                    end
                    ARK0: begin
                        r_aesState <= r_ptLatch ^ round_key;
                        r_roundIdx <= 4'd1;
                        r_subEn    <= 1'b1;
                        r_fsm      <= SUB_REQ;
                    end
                    SUB_REQ: begin
`ifdef AES_SUB_TIMEOUT_EN
                        r_waitCnt <= '0;
`endif
                        r_fsm <= SUB_WAIT;
                    end
                    SUB_WAIT: begin
                        if (sub_valid) begin
                            r_aesState <= sub_result;
                            r_fsm      <= ROUND;
                        end
`ifdef AES_SUB_TIMEOUT_EN
                        else if (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            r_err <= 1'b1;
                            r_fsm <= ERR;
                        end else begin
                            r_waitCnt <= r_waitCnt + 1'b1;
                        end
`endif
                    end
                    ROUND: begin
                        r_aesState <= w_roundOut;
                        if (r_roundIdx == 4'd10) begin
                            r_ct       <= w_roundOut;
                            r_roundIdx <= '0;
                            r_done     <= 1'b1;
                            r_fsm      <= DONE;
                        end else begin
                            r_roundIdx <= r_roundIdx + 4'd1;
                            r_subEn    <= 1'b1;
                            r_fsm      <= SUB_REQ;
                        end
                    end
                    DONE: begin
                        r_busy <= 1'b0;
                        r_fsm  <= IDLE;
                    end
`ifdef AES_SUB_TIMEOUT_EN
                    ERR: begin
                        r_fsm <= ERR;
                    end
`endif
                    default: begin
                        r_busy <= 1'b0;
                        r_fsm  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: FIPS-197 vectors, SubBytes latency, abort, reset, optional timeout.
// Build with AES_SUB_TIMEOUT_EN defined to exercise the timeout path as well.
module tb_aes_round_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [127:0] pt;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         sub_en;
    logic [127:0] sub_data;
    logic         sub_valid = 1'b0;
    logic [127:0] sub_result = '0;
    logic         busy;
    logic         done;
    logic [127:0] ct;
`ifdef AES_SUB_TIMEOUT_EN
    logic         err;
`endif

    logic [7:0]   sbox [0:255];
    logic [127:0] rkTab [0:15];
    int           checks = 0;
    int           passes = 0;
    int           cyc = 0;
    int           enPulses = 0;
    int           subDelay = 1;
    bit           spurious = 1'b0;
    bit           respOn = 1'b1;

    aes_round_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pt         (pt),
        .round_key  (round_key),
        .round_idx  (round_idx),
        .sub_en     (sub_en),
        .sub_data   (sub_data),
        .sub_valid  (sub_valid),
        .sub_result (sub_result),
        .busy       (busy),
        .done       (done),
        .ct         (ct)
`ifdef AES_SUB_TIMEOUT_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (sub_en) enPulses <= enPulses + 1;

    always_comb round_key = rkTab[round_idx];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    function automatic logic [127:0] subBytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
        return o;
    endfunction

    // S-box derived from the GF(2^8) inverse (x^254) and the FIPS-197 affine map.
    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            sbox[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic loadKey(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rkTab[r] = '0;
        for (int r = 0; r < 11; r++) rkTab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // SubBytes model: answers subDelay cycles after sub_en; optionally leaves a garbage valid up through ROUND.
    always begin
        logic [127:0] captured;
        @(negedge clk);
        if (sub_en && respOn) begin
            captured  = sub_data;
            sub_valid = 1'b0;
            repeat (subDelay) @(negedge clk);
            sub_result = subBytes(captured);
            sub_valid  = 1'b1;
            @(negedge clk);
            if (spurious) sub_result = ~sub_result;
            else          sub_valid  = 1'b0;
        end else begin
            sub_valid = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        else
            passes++;
    endtask

    // Runs one full encryption from a negedge; optionally pulses start at op cycles 5 and 20 with a different pt.
    task automatic applyStimulus(input string tag, input logic [127:0] ptIn, input int delay,
                                 input bit noisy, input logic [127:0] expCt, input int expLat);
        int lat;
        int en0;
        bit seen;
        lat      = -1;
        seen     = 1'b0;
        subDelay = delay;
        spurious = noisy;
        en0      = enPulses;
        pt       = ptIn;
        start    = 1'b1;
        for (int k = 1; k <= 300 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) checkOutput({tag, "_busy"}, 128'(busy), 128'(1));
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
            start = noisy && (k == 5 || k == 20);
            pt    = noisy ? ~ptIn : ptIn;
        end
        start = 1'b0;
        checkOutput({tag, "_latency"}, 128'(lat), 128'(expLat));
        checkOutput({tag, "_ct"}, ct, expCt);
        checkOutput({tag, "_subEnCount"}, 128'(enPulses - en0), 128'(10));
        @(negedge clk);
        checkOutput({tag, "_idleBusy"}, 128'(busy), 128'(0));
        checkOutput({tag, "_doneOnce"}, 128'(done), 128'(0));
        checkOutput({tag, "_idx0"}, 128'(round_idx), 128'(0));
        checkOutput({tag, "_ctHeld"}, ct, expCt);
        spurious = 1'b0;
    endtask

    initial begin
        int doneSeen;
        bit found;
        bit prevEn;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pt    = '0;
        buildSbox();
        loadKey(FIPS_KEY);
        repeat (3) @(negedge clk);
        checkOutput("rst_idx", 128'(round_idx), 128'(0));
        checkOutput("rst_subEn", 128'(sub_en), 128'(0));
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_done", 128'(done), 128'(0));
        checkOutput("rst_ct", ct, '0);
        checkOutput("rst_subData", sub_data, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        start = 1'b1;
        abort = 1'b1;
        pt    = FIPS_PT;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("startAbortIdle_busy", 128'(busy), 128'(0));
        repeat (2) @(negedge clk);

        applyStimulus("fips_d1", FIPS_PT, 1, 1'b0, FIPS_CT, 32);
        applyStimulus("fips_d3", FIPS_PT, 3, 1'b0, FIPS_CT, 52);
        applyStimulus("fips_noise", FIPS_PT, 1, 1'b1, FIPS_CT, 32);
        loadKey(C1_KEY);
        applyStimulus("c1_d2", C1_PT, 2, 1'b0, C1_CT, 42);
        loadKey(FIPS_KEY);

        // Abort in the first SUB_WAIT cycle of round 4.
        subDelay = 3;
        pt       = '0;
        start    = 1'b1;
        found    = 1'b0;
        prevEn   = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (round_idx == 4'd4 && prevEn) found = 1'b1;
            else prevEn = sub_en;
        end
        checkOutput("abort_reachedR4Wait", 128'(found), 128'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", 128'(busy), 128'(0));
        checkOutput("abort_idx", 128'(round_idx), 128'(0));
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("abort_noDone", 128'(doneSeen), 128'(0));
        checkOutput("abort_ctHeld", ct, C1_CT);
        checkOutput("abort_stillIdle", 128'(busy), 128'(0));
        applyStimulus("afterAbort", FIPS_PT, 1, 1'b0, FIPS_CT, 32);

        // Asynchronous reset while round 7 is in flight.
        subDelay = 1;
        pt       = C1_PT;
        start    = 1'b1;
        found    = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (round_idx == 4'd7) found = 1'b1;
        end
        checkOutput("reset_reachedR7", 128'(found), 128'(1));
        rst = 1'b0;
        #1;
        checkOutput("midRst_idx", 128'(round_idx), 128'(0));
        checkOutput("midRst_subEn", 128'(sub_en), 128'(0));
        checkOutput("midRst_busy", 128'(busy), 128'(0));
        checkOutput("midRst_done", 128'(done), 128'(0));
        checkOutput("midRst_ct", ct, '0);
        checkOutput("midRst_subData", sub_data, '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus("afterReset", FIPS_PT, 1, 1'b0, FIPS_CT, 32);

`ifdef AES_SUB_TIMEOUT_EN
        // SubBytes never answers: err after 15 SUB_WAIT cycles, cleared by abort.
        respOn = 1'b0;
        pt     = FIPS_PT;
        start  = 1'b1;
        found  = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (sub_en) found = 1'b1;
        end
        checkOutput("to_subEnSeen", 128'(found), 128'(1));
        repeat (15) @(negedge clk);
        checkOutput("to_errNotYet", 128'(err), 128'(0));
        @(negedge clk);
        checkOutput("to_err", 128'(err), 128'(1));
        checkOutput("to_busy", 128'(busy), 128'(1));
        repeat (3) @(negedge clk);
        checkOutput("to_errHeld", 128'(err), 128'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("to_abortErr", 128'(err), 128'(0));
        checkOutput("to_abortBusy", 128'(busy), 128'(0));
        respOn = 1'b1;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
